// File: rtl/noise_lfsr_gen.sv
// Noise channel generator: period counter / tone-sync clocking feeding a
// tap-masked LFSR, with write-triggered reseed and a zero-state lockup guard.
module noise_lfsr_gen #(
  parameter int unsigned LFSR_BITS    = 15,
  parameter int unsigned COUNTER_BITS = 10,
  parameter int unsigned BASE_PERIOD  = 32,
  parameter bit          SYNC_TO_TONE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    wr_strobe,
  input  logic [2:0]              wr_data,
  input  logic [COUNTER_BITS-1:0] tone_freq,
  input  logic                    tone_edge,
  input  logic [LFSR_BITS-1:0]    tap_mask,
  output logic                    out,
  output logic                    shift_pulse,
  output logic [LFSR_BITS-1:0]    lfsr_state
);

  localparam int unsigned CW = COUNTER_BITS + 1;
  localparam logic [LFSR_BITS-1:0] SEED = {1'b1, {(LFSR_BITS-1){1'b0}}};
  localparam logic [CW-1:0] RELOAD_X1 = CW'(BASE_PERIOD - 1);
  localparam logic [CW-1:0] RELOAD_X2 = CW'(2 * BASE_PERIOD - 1);
  localparam logic [CW-1:0] RELOAD_X4 = CW'(4 * BASE_PERIOD - 1);

  typedef enum logic [1:0] {
    NF_BASE = 2'b00,
    NF_X2   = 2'b01,
    NF_X4   = 2'b10,
    NF_TONE = 2'b11
  } nf_e;

  logic [2:0]              r_ctrl;
  logic [CW-1:0]           r_counter;
  logic [LFSR_BITS-1:0]    r_lfsr;
  logic                    r_shift_pulse;

  nf_e                     w_nf;
  logic                    w_white;
  logic                    w_sync_mode;
  logic [COUNTER_BITS-1:0] w_tf_eff;
  logic [CW-1:0]           w_reload;
  logic                    w_shift;
  logic                    w_fb;
  logic [LFSR_BITS-1:0]    w_lfsr_next;

  assign w_nf        = nf_e'(r_ctrl[1:0]);
  assign w_white     = r_ctrl[2];
  assign w_sync_mode = (w_nf == NF_TONE) && SYNC_TO_TONE;

  // Reload value P-1 for the current mode; tone_freq=0 behaves as 1 (P=2)
  always_comb begin
    w_tf_eff = tone_freq;
    if (tone_freq == '0) w_tf_eff = COUNTER_BITS'(1);
    w_reload = RELOAD_X1;
    case (w_nf)
      NF_BASE: w_reload = RELOAD_X1;
      NF_X2:   w_reload = RELOAD_X2;
      NF_X4:   w_reload = RELOAD_X4;
      NF_TONE: w_reload = {w_tf_eff, 1'b0} - CW'(1);
      default: w_reload = RELOAD_X1;
    endcase
  end

  // Shift request, feedback bit and next LFSR value (zero state reseeds)
  always_comb begin
    w_shift     = clk_en && (w_sync_mode ? tone_edge : (r_counter == '0));
    w_fb        = w_white ? (^(r_lfsr & tap_mask)) : r_lfsr[0];
    w_lfsr_next = {w_fb, r_lfsr[LFSR_BITS-1:1]};
    if (r_lfsr == '0) w_lfsr_next = SEED;
  end

  // Control register: loaded by register writes
  always_ff @(posedge clk) begin
    if (reset)          r_ctrl <= '0;
    else if (wr_strobe) r_ctrl <= wr_data;
  end

  // Period counter: free-runs on clk_en in counter modes, holds in sync mode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_counter <= '0;
    end else if (clk_en && !w_sync_mode) begin
      if (r_counter == '0) r_counter <= w_reload;
      else                 r_counter <= r_counter - CW'(1);
    end
  end

  // LFSR: a write reseeds and overrides any shift due in the same cycle
  always_ff @(posedge clk) begin
    if (reset)          r_lfsr <= SEED;
    else if (wr_strobe) r_lfsr <= SEED;
    else if (w_shift)   r_lfsr <= w_lfsr_next;
  end

  // Shift pulse: registered alongside the LFSR update, so it is visible
  // in the cycle that presents the new LFSR value
  always_ff @(posedge clk) begin
    if (reset) r_shift_pulse <= 1'b0;
    else       r_shift_pulse <= w_shift && !wr_strobe;
  end

  assign out         = r_lfsr[0];
  assign shift_pulse = r_shift_pulse;
  assign lfsr_state  = r_lfsr;

endmodule

// File: tb/tb_noise_lfsr_gen.sv
// Directed bench for noise_lfsr_gen: one instance in tone-sync NF=11 mode,
// a second with the internal 2*tone_freq period for NF=11.
module tb_noise_lfsr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        wr_strobe;
  logic [2:0]  wr_data;
  logic [9:0]  tone_freq;
  logic        tone_edge;
  logic [14:0] tap_mask;
  logic        out1, sp1, out2, sp2;
  logic [14:0] st1, st2;

  int checks = 0;
  int errors = 0;
  int n;
  int cnt;

  always #5 clk = ~clk;

  noise_lfsr_gen dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .wr_strobe(wr_strobe),
    .wr_data(wr_data), .tone_freq(tone_freq), .tone_edge(tone_edge),
    .tap_mask(tap_mask), .out(out1), .shift_pulse(sp1), .lfsr_state(st1)
  );

  noise_lfsr_gen #(.SYNC_TO_TONE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .wr_strobe(wr_strobe),
    .wr_data(wr_data), .tone_freq(tone_freq), .tone_edge(tone_edge),
    .tap_mask(tap_mask), .out(out2), .shift_pulse(sp2), .lfsr_state(st2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until the chosen instance pulses shift_pulse (bounded); optionally
  // toggles clk_en before every edge.
  task automatic wait_shift(input bit which, input int bound, input bit toggle_en, output int cycles);
    cycles = 0;
    do begin
      if (toggle_en) clk_en = ~clk_en;
      tick();
      cycles++;
    end while (!(which ? sp2 : sp1) && cycles < bound);
  endtask

  task automatic write(input logic [2:0] d);
    wr_strobe = 1'b1;
    wr_data   = d;
    tick();
    wr_strobe = 1'b0;
  endtask

  task automatic pulses(input int k);
    tone_edge = 1'b1;
    repeat (k) tick();
    tone_edge = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; wr_strobe = 1'b0; wr_data = 3'b000;
    tone_edge = 1'b0; tone_freq = 10'd5; tap_mask = 15'h0003;
    repeat (3) tick();
    check("rst_lfsr", 32'(st1), 32'h4000);
    check("rst_out", 32'(out1), 32'h0);
    check("rst_pulse", 32'(sp1), 32'h0);
    check("rst_lfsr2", 32'(st2), 32'h4000);

    // First enabled cycle after reset shifts, then every 32 cycles
    reset = 1'b0;
    tick();
    check("first_pulse", 32'(sp1), 32'h1);
    check("first_lfsr", 32'(st1), 32'h2000);
    wait_shift(1'b0, 100, 1'b0, n);
    check("nf00_gap1", 32'(n), 32'd32);
    check("nf00_lfsr2", 32'(st1), 32'h1000);
    wait_shift(1'b0, 100, 1'b0, n);
    check("nf00_gap2", 32'(n), 32'd32);
    check("nf00_lfsr3", 32'(st1), 32'h0800);

    // Periodic mode, NF=01
    write(3'b001);
    check("wr_reseed", 32'(st1), 32'h4000);
    check("wr_nopulse", 32'(sp1), 32'h0);
    wait_shift(1'b0, 100, 1'b0, n);
    check("per_s1", 32'(st1), 32'h2000);
    wait_shift(1'b0, 100, 1'b0, n);
    check("nf01_gap", 32'(n), 32'd64);
    for (int i = 3; i <= 14; i++) wait_shift(1'b0, 100, 1'b0, n);
    check("per_s14", 32'(st1), 32'h0001);
    check("per_out14", 32'(out1), 32'h1);
    wait_shift(1'b0, 100, 1'b0, n);
    check("per_s15", 32'(st1), 32'h4000);
    check("per_out15", 32'(out1), 32'h0);

    // White noise, taps 0x0003: full period, driven by tone_edge for speed
    write(3'b111);
    tone_edge = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (st1 !== 15'h4000 && n < 40000);
    tone_edge = 1'b0;
    check("white_period", 32'(n), 32'd32767);

    // Taps 0x0009: seed falls right until bit3 is set after 11 shifts,
    // the 12th shift then feeds back a 1
    tap_mask = 15'h0009;
    write(3'b111);
    pulses(3);
    check("t9_s3", 32'(st1), 32'h0800);
    pulses(8);
    check("t9_s11", 32'(st1), 32'h0008);
    pulses(1);
    check("t9_s12", 32'(st1), 32'h4004);

    // Sync mode; writes done with clk_en=0 so the counter phase is fixed
    tap_mask = 15'h0003;
    write(3'b000);
    wait_shift(1'b0, 100, 1'b0, n);
    clk_en = 1'b0;
    write(3'b111);
    cnt = 0;
    for (int c = 1; c <= 50; c++) begin
      tone_edge = (c == 10) || (c == 25) || (c == 40);
      clk_en    = (c != 25);
      tick();
      if (sp1) cnt++;
    end
    tone_edge = 1'b0;
    clk_en = 1'b0;
    check("sync_count", 32'(cnt), 32'd2);
    check("sync_lfsr", 32'(st1), 32'h1000);
    write(3'b000);
    clk_en = 1'b1;
    wait_shift(1'b0, 100, 1'b0, n);
    check("sync_cnt_held", 32'(n), 32'd32);

    // Internal NF=11 period on the second instance
    write(3'b111);
    wait_shift(1'b1, 100, 1'b0, n);
    wait_shift(1'b1, 100, 1'b0, n);
    check("tf5_gap", 32'(n), 32'd10);
    tone_freq = 10'd0;
    wait_shift(1'b1, 100, 1'b0, n);
    wait_shift(1'b1, 100, 1'b0, n);
    check("tf0_gap", 32'(n), 32'd2);
    wait_shift(1'b1, 100, 1'b1, n);
    wait_shift(1'b1, 100, 1'b1, n);
    check("tf0_toggle_gap", 32'(n), 32'd4);
    tone_freq = 10'd5;
    wait_shift(1'b1, 100, 1'b1, n);
    wait_shift(1'b1, 100, 1'b1, n);
    check("tf5_toggle_gap", 32'(n), 32'd20);
    clk_en = 1'b1;

    // Write landing on a counter==0 cycle
    write(3'b000);
    wait_shift(1'b0, 100, 1'b0, n);
    repeat (31) tick();
    write(3'b000);
    check("wrcol_lfsr", 32'(st1), 32'h4000);
    check("wrcol_pulse", 32'(sp1), 32'h0);

    // Lockup guard: with no taps the seed drains to zero after 15 shifts
    tap_mask = 15'h0000;
    write(3'b111);
    pulses(15);
    check("zero_state", 32'(st1), 32'h0000);
    pulses(1);
    check("guard_lfsr", 32'(st1), 32'h4000);
    check("guard_pulse", 32'(sp1), 32'h1);

    // Reset mid-run
    tap_mask = 15'h0003;
    write(3'b001);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_lfsr", 32'(st1), 32'h4000);
    check("mid_rst_pulse", 32'(sp1), 32'h0);
    check("mid_rst_lfsr2", 32'(st2), 32'h4000);
    tick();
    check("mid_rst_first", 32'(sp1), 32'h1);
    check("mid_rst_lfsr_s1", 32'(st1), 32'h2000);
    wait_shift(1'b0, 100, 1'b0, n);
    check("mid_rst_gap", 32'(n), 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
